// File: rtl/golomb_k_sequencer_pkg.sv
// Shared constants, FSM encoding and helpers for the Golomb-k sequencer.
//  A_LENGTH : width of accumulated-error operand A
//  N_LENGTH : width of occurrence count N
//  K_LENGTH : width of k_index and the computed k
//  MAX_ITER : maximum number of compare iterations per request
package golomb_k_sequencer_pkg;

    localparam int A_LENGTH = 16;
    localparam int N_LENGTH = 7;
    localparam int K_LENGTH = 5;
    localparam int MAX_ITER = 15;
    localparam int ITER_W   = $clog2(MAX_ITER);
    localparam int CMP_W    = A_LENGTH + MAX_ITER;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Increment k, holding at all-ones instead of wrapping.
    function automatic logic [K_LENGTH-1:0] sat_inc_k(input logic [K_LENGTH-1:0] k_in);
        logic [K_LENGTH-1:0] k_out;
        if (k_in == {K_LENGTH{1'b1}}) begin
            k_out = k_in;
        end else begin
            k_out = k_in + {{(K_LENGTH-1){1'b0}}, 1'b1};
        end
        return k_out;
    endfunction

endpackage

// File: rtl/golomb_k_sequencer_k_iter_unit.sv
// Iterative k computation: holds the granted operands, shifts N left by the
// iteration index and compares against A, one compare per step.
//  clk, rst_n : clock, asynchronous active-low reset
//  load       : capture a_in/n_in/kidx_in, restart iteration at i=0
//  step       : perform one compare this cycle
//  a_in, n_in, kidx_in : operands of the granted request
//  done       : this step is the final one (compare not less, or last index)
//  k          : running / final k, registered
module k_iter_unit
    import golomb_k_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic [A_LENGTH-1:0] a_in,
    input  logic [N_LENGTH-1:0] n_in,
    input  logic [K_LENGTH-1:0] kidx_in,
    output logic                done,
    output logic [K_LENGTH-1:0] k
);

    logic [A_LENGTH-1:0] a_r;
    logic [N_LENGTH-1:0] n_r;
    logic [ITER_W-1:0]   i_r;
    logic [K_LENGTH-1:0] k_r;

    logic [CMP_W-1:0]    n_shift_s;
    logic [CMP_W-1:0]    a_ext_s;
    logic                less_s;
    logic                last_s;

    // Compare at full width so N<<i never loses bits; monotone in i, so the
    // first "not less" ends the search exactly.
    always_comb begin
        n_shift_s = {{(CMP_W-N_LENGTH){1'b0}}, n_r} << i_r;
        a_ext_s   = {{MAX_ITER{1'b0}}, a_r};
        less_s    = (n_shift_s < a_ext_s);
        last_s    = (i_r == ITER_W'(MAX_ITER-1));
        done      = step & (~less_s | last_s);
    end

    // Operand, iteration index and k registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= {A_LENGTH{1'b0}};
            n_r <= {N_LENGTH{1'b0}};
            i_r <= {ITER_W{1'b0}};
            k_r <= {K_LENGTH{1'b0}};
        end else if (load) begin
            a_r <= a_in;
            n_r <= n_in;
            i_r <= {ITER_W{1'b0}};
            k_r <= kidx_in;
        end else if (step) begin
            if (less_s) begin
                k_r <= sat_inc_k(k_r);
            end else begin
                k_r <= k_r;
            end
            if (!done) begin
                i_r <= i_r + ITER_W'(1);
            end else begin
                i_r <= i_r;
            end
        end else begin
            k_r <= k_r;
            i_r <= i_r;
        end
    end

    assign k = k_r;

endmodule

// File: rtl/golomb_k_sequencer.sv
// Golomb-k engine shared by regular-mode (port 0) and run-interruption
// (port 1) requesters through a round-robin arbiter.
//  clk, rst_n : clock, asynchronous active-low reset
//  req_valid  : per-port request valid
//  req_A/N/kidx : per-port operands, port x in slice x
//  req_ready  : one-hot grant, only in IDLE
//  rsp_valid/rsp_ready : result handshake
//  rsp_k, rsp_id : computed k and owning port
//  busy       : high while iterating or holding a result
module golomb_k_sequencer
    import golomb_k_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    input  logic [2*A_LENGTH-1:0] req_A,
    input  logic [2*N_LENGTH-1:0] req_N,
    input  logic [2*K_LENGTH-1:0] req_kidx,
    output logic [1:0]            req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [K_LENGTH-1:0]   rsp_k,
    output logic                  rsp_id,
    output logic                  busy
);

    state_t              state_r;
    state_t              state_s;
    logic                prio_r;      // port favoured when both request
    logic                rsp_id_r;
    logic                rsp_valid_r;
    logic                busy_r;

    logic                grant_s;
    logic                any_valid_s;
    logic [1:0]          req_ready_s;
    logic                load_s;
    logic                step_s;
    logic                done_s;
    logic [A_LENGTH-1:0] a_sel_s;
    logic [N_LENGTH-1:0] n_sel_s;
    logic [K_LENGTH-1:0] kidx_sel_s;

    // Round-robin winner and operand select for the winner.
    always_comb begin
        any_valid_s = |req_valid;
        if (req_valid == 2'b11) begin
            grant_s = prio_r;
        end else if (req_valid[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        a_sel_s    = grant_s ? req_A[2*A_LENGTH-1:A_LENGTH]       : req_A[A_LENGTH-1:0];
        n_sel_s    = grant_s ? req_N[2*N_LENGTH-1:N_LENGTH]       : req_N[N_LENGTH-1:0];
        kidx_sel_s = grant_s ? req_kidx[2*K_LENGTH-1:K_LENGTH]    : req_kidx[K_LENGTH-1:0];
    end

    // Next-state logic and per-state controls.
    always_comb begin
        state_s     = state_r;
        req_ready_s = 2'b00;
        load_s      = 1'b0;
        step_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    req_ready_s[grant_s] = 1'b1;
                    load_s               = 1'b1;
                    state_s              = ST_ITER;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                step_s = 1'b1;
                if (done_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ITER;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, arbiter pointer and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            prio_r      <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            if (load_s) begin
                prio_r   <= ~grant_s;
                rsp_id_r <= grant_s;
                busy_r   <= 1'b1;
            end else if ((state_r == ST_DONE) && rsp_ready) begin
                busy_r   <= 1'b0;
            end else begin
                busy_r   <= busy_r;
            end
            if ((state_r == ST_ITER) && done_s) begin
                rsp_valid_r <= 1'b1;
            end else if ((state_r == ST_DONE) && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
        end
    end

    k_iter_unit u_k_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_s),
        .step    (step_s),
        .a_in    (a_sel_s),
        .n_in    (n_sel_s),
        .kidx_in (kidx_sel_s),
        .done    (done_s),
        .k       (rsp_k)
    );

    // Grant is combinational from IDLE; force it low while reset is held so
    // no grant is visible before the first clock after release.
    assign req_ready = req_ready_s & {2{rst_n}};
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_golomb_k_sequencer.sv
module tb_golomb_k_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [31:0] req_A;
    logic [13:0] req_N;
    logic [9:0]  req_kidx;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_k;
    logic        rsp_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    golomb_k_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_A     (req_A),
        .req_N     (req_N),
        .req_kidx  (req_kidx),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_k     (rsp_k),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic set_port(input int p, input int a, input int n, input int kx);
        if (p == 0) begin
            req_A[15:0] = a[15:0]; req_N[6:0] = n[6:0]; req_kidx[4:0] = kx[4:0];
        end else begin
            req_A[31:16] = a[15:0]; req_N[13:7] = n[6:0]; req_kidx[9:5] = kx[4:0];
        end
    endtask

    // Cycles from accept edge until rsp_valid; -1 if the bound expires.
    task automatic wait_rsp(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                cyc = c;
                break;
            end
        end
    endtask

    function automatic int model_k(input int a, input int n, input int kx);
        int k;
        longint sh;
        k = kx;
        for (int i = 0; i < 15; i++) begin
            sh = longint'(n) << i;
            if (sh < longint'(a)) begin
                if (k < 31) k++;
            end else begin
                break;
            end
        end
        return k;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
        req_A = 32'd0; req_N = 14'd0; req_kidx = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_k, rsp_id, busy} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b v=%b k=%0d id=%b busy=%b want all zero",
                     req_ready, rsp_valid, rsp_k, rsp_id, busy);
        end
    endtask

    // Tie at reset exit: port0 wins, then port1 is served.
    task automatic test_tie_at_reset();
        int cyc;
        set_port(0, 0, 5, 3);
        set_port(1, 100, 3, 0);
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL tie_ready_in_reset got %b want 00", req_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL tie_grant0 got %b want 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b10;
        wait_rsp(cyc);
        checks++;
        if (cyc !== 1) begin errors++; $display("FAIL tie_p0_latency got %0d want 1", cyc); end
        checks++;
        if ({rsp_id, rsp_k} !== {1'b0, 5'd3}) begin errors++; $display("FAIL tie_p0_result got id=%b k=%0d want id=0 k=3", rsp_id, rsp_k); end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, req_ready} !== {1'b0, 2'b10}) begin errors++; $display("FAIL tie_grant1 got v=%b ready=%b want v=0 ready=10", rsp_valid, req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(cyc);
        checks++;
        if (cyc !== 7) begin errors++; $display("FAIL tie_p1_latency got %0d want 7", cyc); end
        checks++;
        if ({rsp_id, rsp_k} !== {1'b1, 5'd6}) begin errors++; $display("FAIL tie_p1_result got id=%b k=%0d want id=1 k=6", rsp_id, rsp_k); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cyc;
        set_port(0, 4, 1, 0);
        req_valid = 2'b01;
        #1;
        checks++;
        if ({req_ready, busy} !== {2'b01, 1'b0}) begin errors++; $display("FAIL basic_grant got ready=%b busy=%b want 01/0", req_ready, busy); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        wait_rsp(cyc);
        checks++;
        if (cyc !== 3) begin errors++; $display("FAIL basic_latency got %0d want 3", cyc); end
        checks++;
        if ({rsp_id, rsp_k} !== {1'b0, 5'd2}) begin errors++; $display("FAIL basic_result got id=%b k=%0d want id=0 k=2", rsp_id, rsp_k); end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_done_one_cycle got v=%b busy=%b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_n_zero_and_saturate();
        int cyc;
        set_port(1, 1, 0, 0);
        req_valid = 2'b10;
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(cyc);
        checks++;
        if (cyc !== 15) begin errors++; $display("FAIL nzero_latency got %0d want 15", cyc); end
        checks++;
        if ({rsp_id, rsp_k} !== {1'b1, 5'd15}) begin errors++; $display("FAIL nzero_result got id=%b k=%0d want id=1 k=15", rsp_id, rsp_k); end
        @(posedge clk); #1;
        set_port(1, 1, 0, 20);
        req_valid = 2'b10;
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(cyc);
        checks++;
        if (cyc !== 15) begin errors++; $display("FAIL sat_latency got %0d want 15", cyc); end
        checks++;
        if (rsp_k !== 5'd31) begin errors++; $display("FAIL sat_result got k=%0d want 31", rsp_k); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        rsp_ready = 1'b0;
        set_port(0, 4, 1, 0);
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(cyc);
        checks++;
        if (cyc !== 3) begin errors++; $display("FAIL bp_latency got %0d want 3", cyc); end
        set_port(0, 0, 1, 7);
        req_valid = 2'b01;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if ({rsp_valid, rsp_k, req_ready, busy} !== {1'b1, 5'd2, 2'b00, 1'b1}) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL bp_stable got %0d bad cycles want 0", bad); end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_handshake_ready got %b want 00", req_ready); end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, req_ready} !== {1'b0, 2'b01}) begin errors++; $display("FAIL bp_after_handshake got v=%b ready=%b want 0/01", rsp_valid, req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(cyc);
        checks++;
        if ({cyc[7:0], rsp_k} !== {8'd1, 5'd7}) begin errors++; $display("FAIL bp_second got lat=%0d k=%0d want lat=1 k=7", cyc, rsp_k); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_iter();
        int cyc;
        set_port(0, 100, 3, 0);
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_port(0, 4, 1, 0);
        set_port(1, 3, 1, 2);
        req_valid = 2'b11;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_k, rsp_id, busy} !== 10'd0) begin
            errors++;
            $display("FAIL midreset_outputs got ready=%b v=%b k=%0d id=%b busy=%b want all zero",
                     req_ready, rsp_valid, rsp_k, rsp_id, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL midreset_tie got %b want 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b10;
        wait_rsp(cyc);
        checks++;
        if ({cyc[7:0], rsp_id, rsp_k} !== {8'd3, 1'b0, 5'd2}) begin errors++; $display("FAIL midreset_p0 got lat=%0d id=%b k=%0d want 3/0/2", cyc, rsp_id, rsp_k); end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL midreset_grant1 got %b want 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(cyc);
        checks++;
        if ({cyc[7:0], rsp_id, rsp_k} !== {8'd3, 1'b1, 5'd4}) begin errors++; $display("FAIL midreset_p1 got lat=%0d id=%b k=%0d want 3/1/4", cyc, rsp_id, rsp_k); end
        @(posedge clk); #1;
    endtask

    // Both ports always valid with random operands: grants alternate, k matches model.
    task automatic test_random_contention();
        int a[2], n[2], kx[2];
        int cyc, exp_k, exp_port, bad_grant, bad_k, timeouts;
        bad_grant = 0; bad_k = 0; timeouts = 0;
        for (int p = 0; p < 2; p++) begin
            a[p] = $urandom_range(0, 65535); n[p] = $urandom_range(0, 127); kx[p] = $urandom_range(0, 31);
            set_port(p, a[p], n[p], kx[p]);
        end
        req_valid = 2'b11;
        exp_port = 0;
        #1;
        for (int r = 0; r < 300; r++) begin
            if (req_ready !== (2'b01 << exp_port)) bad_grant++;
            exp_k = model_k(a[exp_port], n[exp_port], kx[exp_port]);
            @(posedge clk); #1;
            a[exp_port] = $urandom_range(0, 65535);
            n[exp_port] = (r % 4 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 127);
            kx[exp_port] = $urandom_range(0, 31);
            set_port(exp_port, a[exp_port], n[exp_port], kx[exp_port]);
            wait_rsp(cyc);
            if (cyc < 0) timeouts++;
            else if ({rsp_id, rsp_k} !== {exp_port[0], exp_k[4:0]}) bad_k++;
            @(posedge clk); #1;
            exp_port = 1 - exp_port;
        end
        req_valid = 2'b00;
        checks++;
        if (bad_grant !== 0) begin errors++; $display("FAIL rand_alternate got %0d bad grants want 0", bad_grant); end
        checks++;
        if (bad_k !== 0) begin errors++; $display("FAIL rand_k got %0d wrong results want 0", bad_k); end
        checks++;
        if (timeouts !== 0) begin errors++; $display("FAIL rand_timeout got %0d timeouts want 0", timeouts); end
    endtask

    initial begin
        test_reset();
        test_tie_at_reset();
        test_basic();
        test_n_zero_and_saturate();
        test_backpressure();
        test_reset_mid_iter();
        test_random_contention();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
